// File: rtl/nubus_master_bist_pkg.sv
// Shared types and constants for the NuBus master BIST traffic generator.
// Optional first-mismatch logging is enabled by defining BIST_ERRLOG_EN.
package nubus_master_bist_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned STRB_W    = 4;
    localparam int unsigned IDX_W     = 16;
    localparam int unsigned LANE_W    = 3;
    localparam int unsigned NUM_LANES = 7;
    localparam int unsigned ERR_W     = 16;

    localparam logic [DATA_W-1:0] DATA_INC   = 32'h0101_0101;
    localparam logic [STRB_W-1:0] WSTRB_READ = 4'b0000;
    localparam logic [STRB_W-1:0] WSTRB_FULL = 4'b1111;

    // Byte-lane mask used for word i, indexed by i mod 7
    localparam logic [0:NUM_LANES-1][STRB_W-1:0] LANES = {
        4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000
    };

    typedef enum logic [3:0] {
        IDLE,
        CLR_REQ,
        CLR_WAIT,
        WR_REQ,
        WR_WAIT,
        RD_REQ,
        RD_WAIT,
        GAP,
        DONE
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } cpu_req_t;

    function automatic logic [STRB_W-1:0] lane_mask(input logic [LANE_W-1:0] lane);
        return (32'(lane) < NUM_LANES) ? LANES[lane] : WSTRB_FULL;
    endfunction

    // Expand a byte strobe into a 32-bit bit mask
    function automatic logic [DATA_W-1:0] lane_expand(input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int b = 0; b < int'(STRB_W); b++) begin
            m[8*b +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/nubus_master_bist_if.sv
// CPU-side request port of the NuBus master, as driven by the BIST.
interface nubus_master_bist_if;
    import nubus_master_bist_pkg::*;

    logic              cpu_valid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [STRB_W-1:0] cpu_wstrb;
    logic              cpu_lock;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;

    modport master (
        output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb, cpu_lock,
        input  cpu_ready, cpu_rdata
    );

    modport slave (
        input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb, cpu_lock,
        output cpu_ready, cpu_rdata
    );

endinterface

// File: rtl/nubus_bist_pattern.sv
// Combinational address/data/mask/expected generator for BIST word i.
module nubus_bist_pattern
    import nubus_master_bist_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'hF000_0000,
    parameter int unsigned       ADDR_STRIDE = 4,
    parameter logic [DATA_W-1:0] SEED        = 32'h8765_4321
) (
    input  logic [IDX_W-1:0]  idx,
    input  logic [LANE_W-1:0] lane,
    output logic [ADDR_W-1:0] word_addr_c,
    output logic [DATA_W-1:0] word_data_c,
    output logic [STRB_W-1:0] word_mask_c,
    output logic [DATA_W-1:0] word_expected_c
);

    localparam logic [ADDR_W-1:0] BASE_ALIGNED = {BASE_ADDR[ADDR_W-1:2], 2'b00};

    always_comb begin
        word_addr_c     = BASE_ALIGNED + ADDR_W'(idx) * ADDR_W'(ADDR_STRIDE);
        word_data_c     = SEED + DATA_W'(idx) * DATA_INC;
        word_mask_c     = lane_mask(lane);
        // Unwritten lanes keep the zero from the clear pass
        word_expected_c = word_data_c & lane_expand(word_mask_c);
    end

endmodule

// File: rtl/nubus_master_bist.sv
// NuBus master BIST: clear, strobed write and read-back compare over an address window.
// Define BIST_ERRLOG_EN to capture address/data of the first read-back mismatch.
module nubus_master_bist
    import nubus_master_bist_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR      = 32'hF000_0000,
    parameter int unsigned       NUM_WORDS      = 7,
    parameter int unsigned       ADDR_STRIDE    = 4,
    parameter logic [DATA_W-1:0] SEED           = 32'h8765_4321,
    parameter int unsigned       TIMEOUT_CLOCKS = 64
) (
    input  logic              nub_clkn,
    input  logic              nub_resetn,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [ERR_W-1:0]  err_count,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_rdata,
    output logic [DATA_W-1:0] err_expected,
    nubus_master_bist_if.master bus
);

    localparam int unsigned        TCNT_W    = $clog2(TIMEOUT_CLOCKS);
    localparam logic [TCNT_W-1:0]  TO_LAST   = TCNT_W'(TIMEOUT_CLOCKS - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_WORDS - 1);
    localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(NUM_LANES - 1);

    state_t             state_q, state_d;
    state_t             phase_q, phase_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
    cpu_req_t           req_q, req_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               timeout_q, timeout_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

    logic [ADDR_W-1:0]  word_addr_c;
    logic [DATA_W-1:0]  word_data_c;
    logic [STRB_W-1:0]  word_mask_c;
    logic [DATA_W-1:0]  word_expected_c;
    logic               mismatch_c;

    nubus_bist_pattern #(
        .BASE_ADDR   (BASE_ADDR),
        .ADDR_STRIDE (ADDR_STRIDE),
        .SEED        (SEED)
    ) u_pattern (
        .idx             (idx_q),
        .lane            (lane_q),
        .word_addr_c     (word_addr_c),
        .word_data_c     (word_data_c),
        .word_mask_c     (word_mask_c),
        .word_expected_c (word_expected_c)
    );

    assign mismatch_c = (bus.cpu_rdata != word_expected_c);

    always_ff @(posedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            state_q   <= IDLE;
            phase_q   <= CLR_REQ;
            idx_q     <= '0;
            lane_q    <= '0;
            tcnt_q    <= '0;
            req_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            idx_q     <= idx_d;
            lane_q    <= lane_d;
            tcnt_q    <= tcnt_d;
            req_q     <= req_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Sequencer: phase_q remembers which pass's *_REQ state to return to after GAP
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        idx_d     = idx_q;
        lane_d    = lane_q;
        tcnt_d    = tcnt_q;
        req_d     = req_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        err_cnt_d = err_cnt_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = CLR_REQ;
                    phase_d   = CLR_REQ;
                    idx_d     = '0;
                    lane_d    = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    err_cnt_d = '0;
                end
            end
            CLR_REQ, WR_REQ, RD_REQ: begin
                valid_d    = 1'b1;
                tcnt_d     = '0;
                req_d.addr = word_addr_c;
                case (state_q)
                    CLR_REQ: begin
                        req_d.wdata = '0;
                        req_d.wstrb = WSTRB_FULL;
                        state_d     = CLR_WAIT;
                    end
                    WR_REQ: begin
                        req_d.wdata = word_data_c;
                        req_d.wstrb = word_mask_c;
                        state_d     = WR_WAIT;
                    end
                    default: begin
                        req_d.wdata = '0;
                        req_d.wstrb = WSTRB_READ;
                        state_d     = RD_WAIT;
                    end
                endcase
            end
            CLR_WAIT, WR_WAIT, RD_WAIT: begin
                if (bus.cpu_ready) begin
                    valid_d = 1'b0;
                    state_d = GAP;
                    if (state_q == RD_WAIT && mismatch_c && err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                end else if (tcnt_q == TO_LAST) begin
                    valid_d   = 1'b0;
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    pass_d    = 1'b0;
                    state_d   = DONE;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            GAP: begin
                if (idx_q == LAST_IDX) begin
                    idx_d  = '0;
                    lane_d = '0;
                    case (phase_q)
                        CLR_REQ: begin
                            phase_d = WR_REQ;
                            state_d = WR_REQ;
                        end
                        WR_REQ: begin
                            phase_d = RD_REQ;
                            state_d = RD_REQ;
                        end
                        default: begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            pass_d  = (err_cnt_q == '0);
                        end
                    endcase
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    lane_d  = (lane_q == LAST_LANE) ? '0 : lane_q + LANE_W'(1);
                    state_d = phase_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign timeout       = timeout_q;
    assign err_count     = err_cnt_q;
    assign bus.cpu_valid = valid_q;
    assign bus.cpu_addr  = req_q.addr;
    assign bus.cpu_wdata = req_q.wdata;
    assign bus.cpu_wstrb = req_q.wstrb;
    assign bus.cpu_lock  = 1'b0;

`ifdef BIST_ERRLOG_EN
    logic [ADDR_W-1:0] log_addr_q;
    logic [DATA_W-1:0] log_rdata_q;
    logic [DATA_W-1:0] log_exp_q;
    logic              log_clear_c;
    logic              log_capture_c;

    assign log_clear_c   = start && (state_q == IDLE || state_q == DONE);
    assign log_capture_c = (state_q == RD_WAIT) && bus.cpu_ready && mismatch_c
                           && (err_cnt_q == '0);

    // First-mismatch log, held until the next accepted start
    always_ff @(posedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            log_addr_q  <= '0;
            log_rdata_q <= '0;
            log_exp_q   <= '0;
        end else if (log_clear_c) begin
            log_addr_q  <= '0;
            log_rdata_q <= '0;
            log_exp_q   <= '0;
        end else if (log_capture_c) begin
            log_addr_q  <= req_q.addr;
            log_rdata_q <= bus.cpu_rdata;
            log_exp_q   <= word_expected_c;
        end
    end

    assign err_addr     = log_addr_q;
    assign err_rdata    = log_rdata_q;
    assign err_expected = log_exp_q;
`else
    assign err_addr     = '0;
    assign err_rdata    = '0;
    assign err_expected = '0;
`endif

endmodule

// File: tb/tb_nubus_master_bist.sv
// Scoreboard bench for nubus_master_bist: memory slave, fault injection, timeout and reset cases.
module tb_nubus_master_bist;
    import nubus_master_bist_pkg::*;

    localparam logic [31:0] BASE = 32'hF000_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          chk_wdata;
    } txn_t;

    typedef struct {
        logic        pass;
        logic [15:0] errc;
        logic        to;
        logic [31:0] ea;
        logic [31:0] er;
        logic [31:0] ee;
    } res_t;

    logic clk;
    logic rst_n;
    logic start_a, start_t, start_n;

    logic busy_a, done_a, pass_a, to_a;
    logic [15:0] errc_a;
    logic [31:0] ea_a, er_a, ee_a;
    logic busy_t, done_t, pass_t, to_t;
    logic [15:0] errc_t;
    logic [31:0] ea_t, er_t, ee_t;
    logic busy_n, done_n, pass_n, to_n;
    logic [15:0] errc_n;
    logic [31:0] ea_n, er_n, ee_n;

    nubus_master_bist_if bus_a();
    nubus_master_bist_if bus_t();
    nubus_master_bist_if bus_n();

    int n_chk = 0;
    int n_fail = 0;

    txn_t exp_q[$];
    res_t res_q[$];

    logic [31:0] data_tab [7] = '{32'h8765_4321, 32'h8866_4422, 32'h8967_4523, 32'h8A68_4624,
                                  32'h8B69_4725, 32'h8C6A_4826, 32'h8D6B_4927};
    logic [3:0]  mask_tab [7] = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [31:0] expt_tab [7] = '{32'h8765_4321, 32'h0000_4422, 32'h8967_0000, 32'h0000_0024,
                                  32'h0000_4700, 32'h006A_0000, 32'h8D00_0000};

    logic [31:0] mem_a [7];
    logic [31:0] mem_n;
    int  wait_clks = 0;
    bit  fault = 0;
    int  n_txn_n = 0;

    nubus_master_bist dut_a (
        .nub_clkn(clk), .nub_resetn(rst_n), .start(start_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .timeout(to_a), .err_count(errc_a),
        .err_addr(ea_a), .err_rdata(er_a), .err_expected(ee_a), .bus(bus_a)
    );

    nubus_master_bist #(.TIMEOUT_CLOCKS(8)) dut_t (
        .nub_clkn(clk), .nub_resetn(rst_n), .start(start_t),
        .busy(busy_t), .done(done_t), .pass(pass_t), .timeout(to_t), .err_count(errc_t),
        .err_addr(ea_t), .err_rdata(er_t), .err_expected(ee_t), .bus(bus_t)
    );

    nubus_master_bist #(.NUM_WORDS(1), .ADDR_STRIDE(8)) dut_n (
        .nub_clkn(clk), .nub_resetn(rst_n), .start(start_n),
        .busy(busy_n), .done(done_n), .pass(pass_n), .timeout(to_n), .err_count(errc_n),
        .err_addr(ea_n), .err_rdata(er_n), .err_expected(ee_n), .bus(bus_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory slave for dut_a with programmable wait states and a bit-0 read fault on word 0
    initial begin
        int wcnt;
        int widx;
        wcnt = 0;
        bus_a.cpu_ready = 1'b0;
        bus_a.cpu_rdata = '0;
        forever begin
            @(negedge clk);
            bus_a.cpu_ready = 1'b0;
            if (bus_a.cpu_valid) begin
                if (wcnt >= wait_clks) begin
                    widx = int'((bus_a.cpu_addr - BASE) >> 2);
                    if (widx >= 0 && widx < 7) begin
                        for (int b = 0; b < 4; b++)
                            if (bus_a.cpu_wstrb[b]) mem_a[widx][8*b +: 8] = bus_a.cpu_wdata[8*b +: 8];
                        bus_a.cpu_rdata = mem_a[widx];
                        if (fault && widx == 0 && bus_a.cpu_wstrb == 4'b0000)
                            bus_a.cpu_rdata = mem_a[widx] ^ 32'h1;
                    end else begin
                        bus_a.cpu_rdata = 32'hBAD0_BAD0;
                    end
                    bus_a.cpu_ready = 1'b1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // dut_t slave never answers; dut_n slave answers on first sample
    initial begin
        bus_t.cpu_ready = 1'b0;
        bus_t.cpu_rdata = '0;
        bus_n.cpu_ready = 1'b0;
        bus_n.cpu_rdata = '0;
        mem_n = 32'h5555_AAAA;
        forever begin
            @(negedge clk);
            bus_n.cpu_ready = 1'b0;
            if (bus_n.cpu_valid) begin
                for (int b = 0; b < 4; b++)
                    if (bus_n.cpu_wstrb[b]) mem_n[8*b +: 8] = bus_n.cpu_wdata[8*b +: 8];
                bus_n.cpu_rdata = mem_n;
                bus_n.cpu_ready = 1'b1;
            end
        end
    end

    // Monitor: pops expected transactions and run results for dut_a
    initial begin
        logic done_prev;
        txn_t t;
        res_t r;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (bus_a.cpu_valid && bus_a.cpu_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL txn_extra: got addr %h strb %b, expected none", bus_a.cpu_addr, bus_a.cpu_wstrb);
                end else begin
                    t = exp_q.pop_front();
                    check("txn_addr", bus_a.cpu_addr, t.addr);
                    check("txn_wstrb", 32'(bus_a.cpu_wstrb), 32'(t.wstrb));
                    if (t.chk_wdata) check("txn_wdata", bus_a.cpu_wdata, t.wdata);
                end
            end
            if (done_a && !done_prev) begin
                if (res_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL done_extra: got done=1, expected no completion");
                end else begin
                    r = res_q.pop_front();
                    check("res_pass", 32'(pass_a), 32'(r.pass));
                    check("res_err_count", 32'(errc_a), 32'(r.errc));
                    check("res_timeout", 32'(to_a), 32'(r.to));
                    check("res_busy", 32'(busy_a), 32'd0);
                    check("res_err_addr", ea_a, r.ea);
                    check("res_err_rdata", er_a, r.er);
                    check("res_err_expected", ee_a, r.ee);
                end
            end
            done_prev = done_a;
        end
    end

    // dut_n monitor: every transaction must target BASE_ADDR
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (bus_n.cpu_valid && bus_n.cpu_ready) begin
                n_txn_n++;
                check("n_txn_addr", bus_n.cpu_addr, BASE);
            end
        end
    end

    task automatic push_run();
        txn_t t;
        for (int i = 0; i < 7; i++) begin
            t = '{BASE + 32'(i) * 4, 32'h0, 4'b1111, 1'b1};
            exp_q.push_back(t);
        end
        for (int i = 0; i < 7; i++) begin
            t = '{BASE + 32'(i) * 4, data_tab[i], mask_tab[i], 1'b1};
            exp_q.push_back(t);
        end
        for (int i = 0; i < 7; i++) begin
            t = '{BASE + 32'(i) * 4, 32'h0, 4'b0000, 1'b0};
            exp_q.push_back(t);
        end
    endtask

    task automatic push_result(input logic p, input logic [15:0] e, input logic to,
                               input logic [31:0] ea, input logic [31:0] er, input logic [31:0] ee);
        res_t r;
        r = '{p, e, to, ea, er, ee};
        res_q.push_back(r);
    endtask

    task automatic pulse_start_a();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int budget, output int busy_cycles);
        bit seen;
        seen = 1'b0;
        busy_cycles = 0;
        for (int k = 0; k < budget; k++) begin
            if (busy_a) busy_cycles++;
            if (done_a) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("done_a_reached", 32'(seen), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        int vc;
        bit found;
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_t = 1'b0;
        start_n = 1'b0;
        for (int i = 0; i < 7; i++) mem_a[i] = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);

        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_pass", 32'(pass_a), 32'd0);
        check("rst_timeout", 32'(to_a), 32'd0);
        check("rst_err_count", 32'(errc_a), 32'd0);
        check("rst_valid", 32'(bus_a.cpu_valid), 32'd0);
        check("rst_addr", bus_a.cpu_addr, 32'd0);
        check("rst_wstrb", 32'(bus_a.cpu_wstrb), 32'd0);
        check("rst_lock", 32'(bus_a.cpu_lock), 32'd0);
        check("rst_err_addr", ea_a, 32'd0);
        rst_n = 1'b1;

        // Five wait clocks: 21 transactions of 8 cycles each
        wait_clks = 5;
        push_run();
        push_result(1'b1, 16'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        pulse_start_a();
        wait_done_a(1000, bc);
        check("busy_cycles_wait5", 32'(bc), 32'd168);
        for (int i = 0; i < 7; i++) check("mem_contents", mem_a[i], expt_tab[i]);

        // Ready on first sample: 3 cycles per transaction
        wait_clks = 0;
        push_run();
        push_result(1'b1, 16'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        pulse_start_a();
        wait_done_a(500, bc);
        check("busy_cycles_wait0", 32'(bc), 32'd63);

        // Bit 0 flipped on read of word 0
        fault = 1'b1;
        push_run();
`ifdef BIST_ERRLOG_EN
        push_result(1'b0, 16'd1, 1'b0, 32'hF000_0000, 32'h8765_4320, 32'h8765_4321);
`else
        push_result(1'b0, 16'd1, 1'b0, 32'd0, 32'd0, 32'd0);
`endif
        pulse_start_a();
        wait_done_a(500, bc);
        fault = 1'b0;

        // Second start while busy is ignored
        push_run();
        push_result(1'b1, 16'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        pulse_start_a();
        repeat (10) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a(500, bc);

        // Reset during WR_WAIT drops cpu_valid without a clock edge
        wait_clks = 5;
        push_run();
        pulse_start_a();
        found = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (bus_a.cpu_valid && bus_a.cpu_wdata != 32'd0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("wr_wait_reached", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus_a.cpu_valid), 32'd0);
        check("arst_busy", 32'(busy_a), 32'd0);
        check("arst_done", 32'(done_a), 32'd0);
        check("arst_wdata", bus_a.cpu_wdata, 32'd0);
        check("arst_wstrb", 32'(bus_a.cpu_wstrb), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_clks = 0;
        push_run();
        push_result(1'b1, 16'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        pulse_start_a();
        wait_done_a(500, bc);
        check("busy_cycles_after_reset", 32'(bc), 32'd63);

        // Timeout with TIMEOUT_CLOCKS=8 and no ready
        @(negedge clk);
        start_t = 1'b1;
        @(negedge clk);
        start_t = 1'b0;
        vc = 0;
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (bus_t.cpu_valid) vc++;
            if (done_t) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t_done_reached", 32'(found), 32'd1);
        check("t_valid_cycles", 32'(vc), 32'd8);
        check("t_timeout", 32'(to_t), 32'd1);
        check("t_pass", 32'(pass_t), 32'd0);
        check("t_err_count", 32'(errc_t), 32'd0);
        check("t_valid_low", 32'(bus_t.cpu_valid), 32'd0);
        check("t_busy", 32'(busy_t), 32'd0);

        // NUM_WORDS=1, ADDR_STRIDE=8: three transactions to BASE_ADDR
        @(negedge clk);
        start_n = 1'b1;
        @(negedge clk);
        start_n = 1'b0;
        bc = 0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (busy_n) bc++;
            if (done_n) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        check("n_done_reached", 32'(found), 32'd1);
        check("n_txn_count", 32'(n_txn_n), 32'd3);
        check("n_busy_cycles", 32'(bc), 32'd9);
        check("n_pass", 32'(pass_n), 32'd1);
        check("n_err_count", 32'(errc_n), 32'd0);

        repeat (3) @(negedge clk);
        check("txn_queue_drained", 32'(exp_q.size()), 32'd0);
        check("res_queue_drained", 32'(res_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nubus_master_bist.md
Name: nubus_master_bist

Overview:
- Synthesizable traffic generator and checker that drives the CPU-side request port of the NuBus master (cpu_valid/cpu_ready handshake).
- Runs three passes over a parametrised address window: clear, strobed pattern write, read-back compare. Reports pass/fail, error count and timeout.
- Used for on-card self-test of master→bus→slave paths and as a reusable bench driver.

Parameters:
- BASE_ADDR, 32'hF000_0000, byte address of word 0 (bits [1:0] ignored, forced 0).
- NUM_WORDS, 7, words in window, 1..65535.
- ADDR_STRIDE, 4, byte increment between words, multiple of 4.
- SEED, 32'h8765_4321, data for word 0.
- TIMEOUT_CLOCKS, 64, max cycles waiting for cpu_ready per transaction, ≥2.

Ports:
- nub_clkn  in  1  clock, all state on rising edge
- nub_resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; ignored while busy
- busy  out  1  run in progress
- done  out  1  high from end of run until next accepted start
- pass  out  1  valid with done: err_count==0 and no timeout
- timeout  out  1  run aborted, cpu_ready not seen within TIMEOUT_CLOCKS
- err_count  out  16  read-back mismatches, saturating at 16'hFFFF
- cpu_valid  out  1  request valid
- cpu_addr  out  32  request byte address
- cpu_wdata  out  32  write data
- cpu_wstrb  out  4  byte enables; 4'b0000 = read
- cpu_lock  out  1  held 0
- cpu_ready  in  1  request complete, sampled on rising edge
- cpu_rdata  in  32  read data, valid when cpu_ready=1
- err_addr  out  32  address of first mismatch (see Optional Feature)
- err_rdata  out  32  data read at first mismatch
- err_expected  out  32  expected data at first mismatch

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Word i: addr_i = BASE_ADDR + i*ADDR_STRIDE (mod 2^32); data_i = SEED + i*32'h0101_0101 (mod 2^32); mask_i = LANES[i mod 7].
- LANES = 1111, 0011, 1100, 0001, 0010, 0100, 1000.
- States: IDLE → CLR_REQ/CLR_WAIT → GAP → WR_REQ/WR_WAIT → GAP → RD_REQ/RD_WAIT → GAP → … → DONE.
  - CLR pass: write 32'h0, wstrb 1111, i = 0..NUM_WORDS-1.
  - WR pass: write data_i, wstrb mask_i.
  - RD pass: read with wstrb 0000.
  - expected_i = per-byte-lane data_i where mask_i is set, else 8'h00.
- Handshake:
  - *_REQ: assert cpu_valid with addr/wdata/wstrb, all held stable until the rising edge on which cpu_ready=1.
  - That edge: cpu_valid←0. In RD, compare cpu_rdata against expected_i on the same edge.
  - Then exactly one GAP cycle with cpu_valid=0.
  - Minimum 3 cycles per transaction when ready returns on first sample.
- cpu_ready while cpu_valid=0: ignored.
- Index wraps to 0 at each pass change; pass ends after index NUM_WORDS-1.
- Timeout:
  - Per-transaction counter cleared on entering *_REQ.
  - If TIMEOUT_CLOCKS edges pass without cpu_ready: cpu_valid←0, timeout←1, go to DONE, pass←0.
- Mismatch: err_count += 1, saturating.
- DONE: busy=0, done=1. pass = (err_count==0 && !timeout).
- start in DONE or IDLE: clears done/pass/timeout/err_count/err_* and begins CLR, busy=1 next cycle.
- start while busy: ignored.
- nub_resetn low mid-transaction: cpu_valid drops immediately (async); run abandoned, no resume.

Optional Feature:
- BIST_ERRLOG_EN defined:
  - err_addr/err_rdata/err_expected capture the first mismatch of a run and hold until the next accepted start.
  - Later mismatches only increment err_count.
- Undefined: these three outputs are tied to 0 and no capture registers exist.

Decomposition:
- Shared package: lane-mask table LANES, state enum, data increment constant 32'h0101_0101, and the existing WSTRB_* encodings.
- One sub-module, nubus_bist_pattern: combinational addr_i/data_i/mask_i/expected_i from index i and parameters.
- FSM, counters and checker stay in the top.

Test Plan:
- Default params with nubus_memory, 5 wait clocks, start pulse → 21 transactions, done=1, pass=1, err_count=0; word 3 expected 32'h8A68_4624 & lane 0 = 32'h0000_0024.
- Slave model with cpu_ready on the first sample → each transaction is 3 cycles; total busy = 63 cycles.
- Slave returning cpu_rdata with bit 0 flipped on word 0 → err_count=1, pass=0. With BIST_ERRLOG_EN: err_addr=32'hF000_0000, err_expected=32'h8765_4321, err_rdata=32'h8765_4320.
- cpu_ready never asserted, TIMEOUT_CLOCKS=8 → cpu_valid drops after 8 edges, timeout=1, done=1, pass=0, err_count=0.
- nub_resetn pulsed low during WR_WAIT → cpu_valid=0 with no clock edge; all outputs 0; a new start runs cleanly to pass=1.
- start asserted while busy → no effect on sequence or counts; NUM_WORDS=1, ADDR_STRIDE=8 → exactly 3 transactions to BASE_ADDR.
